// File: rtl/musa_stack_pkg.sv
// rtl/musa_stack_pkg.sv - shared constants and operation decode for the stack unit
package musa_stack_pkg;

   localparam int DATA_WIDTH_DEF = 32;
   localparam int DEPTH_DEF      = 16;

   // Encoding follows {push, pop} so decode is a plain cast
   typedef enum logic [1:0] {
      NOP     = 2'b00,
      POP     = 2'b01,
      PUSH    = 2'b10,
      REPLACE = 2'b11
   } stack_op_e;

   function automatic stack_op_e decode_op(input logic push, input logic pop);
      return stack_op_e'({push, pop});
   endfunction

endpackage

// File: rtl/stack_unit_if.sv
// rtl/stack_unit_if.sv - decode-side request and status bundle for the stack unit
interface stack_unit_if
   import musa_stack_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
);
   localparam int ADDR_WIDTH = $clog2(DEPTH);

   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  clear_err;
   logic [DATA_WIDTH-1:0] pop_data;
   logic                  pop_valid;
   logic [ADDR_WIDTH:0]   count;
   logic                  empty;
   logic                  full;
   logic                  overflow;
   logic                  underflow;

   // Decode stage drives requests and observes status
   modport master (
      output push, pop, push_data, clear_err,
      input  pop_data, pop_valid, count, empty, full, overflow, underflow
   );

   // The stack unit consumes requests and reports status
   modport slave (
      input  push, pop, push_data, clear_err,
      output pop_data, pop_valid, count, empty, full, overflow, underflow
   );

endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - unreset storage array with one sync write and one async read
module stack_ram
   import musa_stack_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Write the addressed entry; contents survive reset on purpose
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - LIFO for push/pop stack instructions with occupancy and sticky error flags
module stack_unit
   import musa_stack_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   stack_unit_if.slave bus
);

   localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH:0]   CNT_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_pop_data;
   logic                  r_pop_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   stack_op_e             w_op;
   logic                  w_empty;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] w_rd_addr;
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [ADDR_WIDTH:0]   w_count_nxt;
   logic                  w_pop_ok;
   logic                  w_ovf_set;
   logic                  w_unf_set;

   assign w_op    = decode_op(bus.push, bus.pop);
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_DEPTH);
   // When full the low bits are zero, so the wrap of the subtraction lands on DEPTH-1
   assign w_rd_addr = r_count[ADDR_WIDTH-1:0] - ADDR_ONE;

   stack_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (bus.push_data),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Decide write, occupancy change and error events for this cycle's request
   always_comb begin
      w_wr_en     = 1'b0;
      w_wr_addr   = r_count[ADDR_WIDTH-1:0];
      w_count_nxt = r_count;
      w_pop_ok    = 1'b0;
      w_ovf_set   = 1'b0;
      w_unf_set   = 1'b0;
      case (w_op)
         PUSH: begin
            if (w_full) begin
               w_ovf_set = 1'b1;
            end else begin
               w_wr_en     = 1'b1;
               w_count_nxt = r_count + CNT_ONE;
            end
         end
         POP: begin
            if (w_empty) begin
               w_unf_set = 1'b1;
            end else begin
               w_pop_ok    = 1'b1;
               w_count_nxt = r_count - CNT_ONE;
            end
         end
         REPLACE: begin
            // Empty: the push still lands at entry 0 while the pop fails
            w_wr_en = 1'b1;
            if (w_empty) begin
               w_count_nxt = CNT_ONE;
               w_unf_set   = 1'b1;
            end else begin
               w_pop_ok  = 1'b1;
               w_wr_addr = w_rd_addr;
            end
         end
         default: ;
      endcase
   end

   // Occupancy, popped-word register and sticky flags; a new error beats clear_err
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count     <= '0;
         r_pop_data  <= '0;
         r_pop_valid <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_count     <= w_count_nxt;
         r_pop_valid <= w_pop_ok;
         if (w_pop_ok) begin
            r_pop_data <= w_rd_data;
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (bus.clear_err) begin
            r_overflow <= 1'b0;
         end
         if (w_unf_set) begin
            r_underflow <= 1'b1;
         end else if (bus.clear_err) begin
            r_underflow <= 1'b0;
         end
      end
   end

   assign bus.pop_data  = r_pop_data;
   assign bus.pop_valid = r_pop_valid;
   assign bus.count     = r_count;
   assign bus.empty     = w_empty;
   assign bus.full      = w_full;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - self-checking bench for stack_unit with a queue-based reference model
module tb_stack_unit;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_pd;
   logic          m_pv;
   logic          m_ovf;
   logic          m_unf;

   stack_unit_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut_if ();

   stack_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dut_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic model_clear();
      m_q.delete();
      m_pd  = '0;
      m_pv  = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic do_reset();
      dut_if.push = 1'b0; dut_if.pop = 1'b0; dut_if.push_data = '0; dut_if.clear_err = 1'b0;
      rst = 1'b0;
      model_clear();
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // One cycle of request; model advanced from the pre-edge state, outputs sampled 1ns after the edge
   task automatic drive(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
      logic e_ovf;
      logic e_unf;
      e_ovf = 1'b0;
      e_unf = 1'b0;
      dut_if.push = p; dut_if.pop = q; dut_if.push_data = d; dut_if.clear_err = c;
      m_pv = 1'b0;
      if (p && q) begin
         if (m_q.size() > 0) begin
            m_pd = m_q[m_q.size()-1];
            m_pv = 1'b1;
            m_q[m_q.size()-1] = d;
         end else begin
            m_q.push_back(d);
            e_unf = 1'b1;
         end
      end else if (p) begin
         if (m_q.size() < DEPTH) m_q.push_back(d);
         else e_ovf = 1'b1;
      end else if (q) begin
         if (m_q.size() > 0) begin
            m_pd = m_q.pop_back();
            m_pv = 1'b1;
         end else e_unf = 1'b1;
      end
      m_ovf = e_ovf | (m_ovf & ~c);
      m_unf = e_unf | (m_unf & ~c);
      @(posedge clk); #1;
      dut_if.push = 1'b0; dut_if.pop = 1'b0; dut_if.clear_err = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (dut_if.count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", dut_if.count); end
      n_tests++; if (dut_if.empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b exp 1", dut_if.empty); end
      n_tests++; if (dut_if.full !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b exp 0", dut_if.full); end
      n_tests++; if (dut_if.pop_data !== 32'h0) begin n_fail++; $display("FAIL rst_pop_data got %h exp 0", dut_if.pop_data); end
      n_tests++; if (dut_if.pop_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pop_valid got %b exp 0", dut_if.pop_valid); end
      n_tests++; if ({dut_if.overflow, dut_if.underflow} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b%b exp 00", dut_if.overflow, dut_if.underflow); end
   endtask

   task automatic test_lifo();
      logic [DW-1:0] w [3];
      w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, w[i], 1'b0);
         n_tests++; if (dut_if.count !== 3'(i+1)) begin n_fail++; $display("FAIL lifo_push_count%0d got %0d exp %0d", i, dut_if.count, i+1); end
         n_tests++; if (dut_if.pop_valid !== 1'b0) begin n_fail++; $display("FAIL lifo_push_valid%0d got %b exp 0", i, dut_if.pop_valid); end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, '0, 1'b0);
         n_tests++; if (dut_if.pop_valid !== 1'b1 || dut_if.pop_data !== w[2-i]) begin n_fail++; $display("FAIL lifo_pop%0d got v=%b d=%h exp v=1 d=%h", i, dut_if.pop_valid, dut_if.pop_data, w[2-i]); end
         n_tests++; if (dut_if.count !== 3'(2-i)) begin n_fail++; $display("FAIL lifo_pop_count%0d got %0d exp %0d", i, dut_if.count, 2-i); end
      end
      n_tests++; if (dut_if.empty !== 1'b1) begin n_fail++; $display("FAIL lifo_empty got %b exp 1", dut_if.empty); end
      drive(1'b0, 1'b0, '0, 1'b0);
      n_tests++; if (dut_if.pop_valid !== 1'b0 || dut_if.pop_data !== 32'h11) begin n_fail++; $display("FAIL lifo_idle got v=%b d=%h exp v=0 d=11", dut_if.pop_valid, dut_if.pop_data); end
   endtask

   task automatic test_overflow();
      logic [DW-1:0] w [4];
      do_reset();
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         drive(1'b1, 1'b0, w[i], 1'b0);
      end
      n_tests++; if (dut_if.full !== 1'b1 || dut_if.count !== 3'd4 || dut_if.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_fill got full=%b cnt=%0d ovf=%b exp 1/4/0", dut_if.full, dut_if.count, dut_if.overflow); end
      drive(1'b1, 1'b0, 32'hFF, 1'b0);
      n_tests++; if (dut_if.full !== 1'b1 || dut_if.count !== 3'd4 || dut_if.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got full=%b cnt=%0d ovf=%b exp 1/4/1", dut_if.full, dut_if.count, dut_if.overflow); end
      drive(1'b0, 1'b1, '0, 1'b0);
      n_tests++; if (dut_if.pop_valid !== 1'b1 || dut_if.pop_data !== w[3]) begin n_fail++; $display("FAIL ovf_pop got v=%b d=%h exp v=1 d=%h", dut_if.pop_valid, dut_if.pop_data, w[3]); end
      n_tests++; if (dut_if.count !== 3'd3 || dut_if.full !== 1'b0) begin n_fail++; $display("FAIL ovf_pop_count got cnt=%0d full=%b exp 3/0", dut_if.count, dut_if.full); end
   endtask

   task automatic test_underflow();
      do_reset();
      drive(1'b1, 1'b0, 32'h5A, 1'b0);
      drive(1'b0, 1'b1, '0, 1'b0);
      drive(1'b0, 1'b1, '0, 1'b0);
      n_tests++; if (dut_if.underflow !== 1'b1 || dut_if.pop_valid !== 1'b0 || dut_if.pop_data !== 32'h5A) begin n_fail++; $display("FAIL unf_pop got unf=%b v=%b d=%h exp 1/0/5a", dut_if.underflow, dut_if.pop_valid, dut_if.pop_data); end
      drive(1'b0, 1'b0, '0, 1'b0);
      n_tests++; if (dut_if.underflow !== 1'b1) begin n_fail++; $display("FAIL unf_sticky got %b exp 1", dut_if.underflow); end
      drive(1'b0, 1'b0, '0, 1'b1);
      n_tests++; if (dut_if.underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clear got %b exp 0", dut_if.underflow); end
      drive(1'b0, 1'b1, '0, 1'b1);
      n_tests++; if (dut_if.underflow !== 1'b1 || dut_if.count !== 3'd0) begin n_fail++; $display("FAIL unf_set_wins got unf=%b cnt=%0d exp 1/0", dut_if.underflow, dut_if.count); end
   endtask

   task automatic test_replace();
      logic [DW-1:0] w [4];
      do_reset();
      drive(1'b1, 1'b0, 32'hA, 1'b0);
      drive(1'b1, 1'b1, 32'hB, 1'b0);
      n_tests++; if (dut_if.pop_valid !== 1'b1 || dut_if.pop_data !== 32'hA || dut_if.count !== 3'd1) begin n_fail++; $display("FAIL rep_swap got v=%b d=%h cnt=%0d exp 1/a/1", dut_if.pop_valid, dut_if.pop_data, dut_if.count); end
      drive(1'b0, 1'b1, '0, 1'b0);
      n_tests++; if (dut_if.pop_data !== 32'hB || dut_if.count !== 3'd0) begin n_fail++; $display("FAIL rep_pop got d=%h cnt=%0d exp b/0", dut_if.pop_data, dut_if.count); end
      for (int i = 0; i < 4; i++) begin
         w[i] = $urandom;
         drive(1'b1, 1'b0, w[i], 1'b0);
      end
      drive(1'b1, 1'b1, 32'hC0DE, 1'b0);
      n_tests++; if (dut_if.count !== 3'd4 || dut_if.overflow !== 1'b0 || dut_if.pop_data !== w[3] || dut_if.pop_valid !== 1'b1) begin n_fail++; $display("FAIL rep_full got cnt=%0d ovf=%b v=%b d=%h exp 4/0/1/%h", dut_if.count, dut_if.overflow, dut_if.pop_valid, dut_if.pop_data, w[3]); end
      drive(1'b0, 1'b1, '0, 1'b0);
      n_tests++; if (dut_if.pop_data !== 32'hC0DE) begin n_fail++; $display("FAIL rep_full_pop got %h exp c0de", dut_if.pop_data); end
   endtask

   task automatic test_replace_empty();
      do_reset();
      drive(1'b1, 1'b1, 32'hC7, 1'b0);
      n_tests++; if (dut_if.count !== 3'd1 || dut_if.underflow !== 1'b1 || dut_if.pop_valid !== 1'b0) begin n_fail++; $display("FAIL rep_empty got cnt=%0d unf=%b v=%b exp 1/1/0", dut_if.count, dut_if.underflow, dut_if.pop_valid); end
      drive(1'b0, 1'b1, '0, 1'b0);
      n_tests++; if (dut_if.pop_valid !== 1'b1 || dut_if.pop_data !== 32'hC7) begin n_fail++; $display("FAIL rep_empty_pop got v=%b d=%h exp 1/c7", dut_if.pop_valid, dut_if.pop_data); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(1'b1, 1'b0, 32'hAA, 1'b0);
      drive(1'b1, 1'b0, 32'hBB, 1'b0);
      drive(1'b1, 1'b0, 32'hCC, 1'b0);
      drive(1'b0, 1'b1, '0, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      n_tests++; if (dut_if.count !== 3'd0 || dut_if.empty !== 1'b1 || dut_if.full !== 1'b0) begin n_fail++; $display("FAIL arst_count got cnt=%0d e=%b f=%b exp 0/1/0", dut_if.count, dut_if.empty, dut_if.full); end
      n_tests++; if (dut_if.pop_data !== 32'h0 || dut_if.pop_valid !== 1'b0) begin n_fail++; $display("FAIL arst_pop got v=%b d=%h exp 0/0", dut_if.pop_valid, dut_if.pop_data); end
      model_clear();
      #2;
      rst = 1'b1;
      drive(1'b0, 1'b1, '0, 1'b0);
      n_tests++; if (dut_if.underflow !== 1'b1 || dut_if.pop_valid !== 1'b0) begin n_fail++; $display("FAIL arst_unf got unf=%b v=%b exp 1/0", dut_if.underflow, dut_if.pop_valid); end
   endtask

   task automatic test_random();
      logic p, q, c;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         p = ($urandom_range(0, 1) == 1);
         q = ($urandom_range(0, 1) == 1);
         c = ($urandom_range(0, 7) == 0);
         drive(p, q, $urandom, c);
         n_tests++;
         if (dut_if.count !== 3'(m_q.size()) || dut_if.empty !== (m_q.size() == 0) ||
             dut_if.full !== (m_q.size() == DEPTH) || dut_if.pop_valid !== m_pv ||
             dut_if.pop_data !== m_pd || dut_if.overflow !== m_ovf || dut_if.underflow !== m_unf) begin
            n_fail++;
            $display("FAIL rand%0d got cnt=%0d e=%b f=%b v=%b d=%h o=%b u=%b exp cnt=%0d v=%b d=%h o=%b u=%b",
                     i, dut_if.count, dut_if.empty, dut_if.full, dut_if.pop_valid, dut_if.pop_data,
                     dut_if.overflow, dut_if.underflow, m_q.size(), m_pv, m_pd, m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b0;
      dut_if.push = 1'b0; dut_if.pop = 1'b0; dut_if.push_data = '0; dut_if.clear_err = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_lifo();
      test_overflow();
      test_underflow();
      test_replace();
      test_replace_empty();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
